fb_flash_loader: RTL and testbench
==================================

FB_FLASH_LOADER -- requirements
Module: fb_flash_loader

Interface
REQ-001 SHALL have parameter N_BANKS, default 2, number of panel banks.
REQ-002 SHALL have parameter N_ROWS, default 32, rows per bank.
REQ-003 SHALL have parameter N_COLS, default 64, pixels per row.
REQ-004 SHALL have parameter BITDEPTH, default 24, pixel width (3 bytes).
REQ-005 SHALL have parameter N_FRAMES, default 4, frames stored in flash.
REQ-006 SHALL have parameter BASE_ADDR, default 24'h100000, flash byte address of frame 0.
REQ-007 clk  in  1  sole clock; all logic rising-edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 enable  in  1  high permits starting a new row fetch.
REQ-010 sr_addr  out  24  flash byte address for the reader.
REQ-011 sr_len  out  16  transfer length minus one, in bytes.
REQ-012 sr_go  out  1  one-cycle fetch start pulse.
REQ-013 sr_rdy  in  1  reader idle and able to accept sr_go.
REQ-014 sr_data  in  8  received byte.
REQ-015 sr_valid  in  1  sr_data valid this cycle.
REQ-016 fbw_row_addr  out  log2(N_BANKS)+log2(N_ROWS)  {bank,row} being written.
REQ-017 fbw_col_addr  out  log2(N_COLS)  pixel column.
REQ-018 fbw_data  out  BITDEPTH  pixel value.
REQ-019 fbw_wren  out  1  pixel write strobe.
REQ-020 fbw_row_store  out  1  one-cycle pulse: row buffer complete.
REQ-021 fbw_row_rdy  in  1  framebuffer has accepted the stored row.
REQ-022 fbw_row_swap  out  1  one-cycle pulse: swap row buffer.
REQ-023 frame_rdy  in  1  display may accept a frame swap.
REQ-024 frame_swap  out  1  one-cycle pulse: swap frame.

Function
REQ-025 SHALL implement states IDLE, REQ, DATA, STORE, ROW_WAIT, ROW_SWAP, FRAME_WAIT, FRAME_SWAP.
REQ-026 IDLE->REQ when enable=1 and sr_rdy=1; otherwise SHALL remain in IDLE.
REQ-027 REQ SHALL assert sr_go for exactly one cycle with sr_addr = BASE_ADDR + frame*N_BANKS*N_ROWS*N_COLS*3 + row*N_COLS*3, computed modulo 2^24, and sr_len = N_COLS*3-1; next state DATA.
REQ-028 In DATA, each sr_valid byte SHALL shift into a 3-byte assembler, first byte into bits [23:16], last into [7:0].
REQ-029 On each third byte, fbw_wren SHALL pulse on the next cycle with fbw_data = assembled pixel and fbw_col_addr = pixel index (0..N_COLS-1), one-cycle latency.
REQ-030 After the write of column N_COLS-1, STORE SHALL pulse fbw_row_store for one cycle, then enter ROW_WAIT.
REQ-031 ROW_WAIT SHALL hold until fbw_row_rdy=1, then ROW_SWAP pulses fbw_row_swap for one cycle.
REQ-032 After ROW_SWAP, row index {bank,row} SHALL increment; if it was not the last row (N_BANKS*N_ROWS-1), next state IDLE; else FRAME_WAIT with row index wrapped to 0.
REQ-033 FRAME_WAIT SHALL hold until frame_rdy=1; FRAME_SWAP pulses frame_swap one cycle, frame index increments wrapping N_FRAMES-1->0, next state IDLE.
REQ-034 sr_valid outside DATA SHALL be ignored; byte assembler and column counter SHALL clear on entry to REQ.
REQ-035 fbw_row_addr SHALL hold the current row index stably from REQ through ROW_SWAP.
REQ-036 enable deasserted mid-row SHALL NOT abort the row; it only blocks the IDLE->REQ transition.
REQ-037 fbw_row_rdy or frame_rdy already high on state entry SHALL advance on the following cycle (no extra wait).

Reset
REQ-038 While rst_n=0: state IDLE, row and frame index 0, assembler 0, all strobes (sr_go, fbw_wren, fbw_row_store, fbw_row_swap, frame_swap) 0, sr_addr=BASE_ADDR, sr_len=N_COLS*3-1, fbw_data 0, fbw_col_addr 0.
REQ-039 Reset asserted mid-operation SHALL abandon the transfer immediately; after release, loading restarts at frame 0, row 0.

Verification
REQ-040 Reset release, enable=1, sr_rdy=1 -> one sr_go, sr_addr=24'h100000, sr_len=191.
REQ-041 Feed 192 bytes 0x00..0xBF -> 64 fbw_wren, column 0 data 24'h000102, column 63 data 24'hBDBEBF, then one fbw_row_store.
REQ-042 Hold fbw_row_rdy=0 for 10 cycles then 1 -> fbw_row_swap exactly once, one cycle after rdy; next sr_addr=24'h1000C0, fbw_row_addr=1.
REQ-043 Complete 64 rows with frame_rdy=0 -> no frame_swap until frame_rdy=1; then one pulse, next sr_addr=24'h103000.
REQ-044 After frame 3 swap -> frame wraps, next sr_addr=24'h100000.
REQ-045 rst_n low during DATA at byte 50, extra sr_valid bytes -> no fbw_wren; after release first sr_go addresses 24'h100000.

Source files
------------

// File: rtl/fb_flash_loader.sv
// fb_flash_loader: fetches panel rows from SPI flash and streams 24-bit pixels into the framebuffer.
// One row per flash transfer; row and frame swaps are handshaked with the framebuffer and display.
module fb_flash_loader #(
    parameter int          N_BANKS   = 2,
    parameter int          N_ROWS    = 32,
    parameter int          N_COLS    = 64,
    parameter int          BITDEPTH  = 24,
    parameter int          N_FRAMES  = 4,
    parameter logic [23:0] BASE_ADDR = 24'h100000
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       enable,
    output logic [23:0]                                sr_addr,
    output logic [15:0]                                sr_len,
    output logic                                       sr_go,
    input  logic                                       sr_rdy,
    input  logic [7:0]                                 sr_data,
    input  logic                                       sr_valid,
    output logic [$clog2(N_BANKS)+$clog2(N_ROWS)-1:0]  fbw_row_addr,
    output logic [$clog2(N_COLS)-1:0]                  fbw_col_addr,
    output logic [BITDEPTH-1:0]                        fbw_data,
    output logic                                       fbw_wren,
    output logic                                       fbw_row_store,
    input  logic                                       fbw_row_rdy,
    output logic                                       fbw_row_swap,
    input  logic                                       frame_rdy,
    output logic                                       frame_swap
);
    localparam int RW = $clog2(N_BANKS) + $clog2(N_ROWS);
    localparam int CW = $clog2(N_COLS);
    localparam int FW = N_FRAMES > 1 ? $clog2(N_FRAMES) : 1;
    localparam logic [RW-1:0] LAST_ROW    = RW'(N_BANKS * N_ROWS - 1);
    localparam logic [FW-1:0] LAST_FRAME  = FW'(N_FRAMES - 1);
    localparam logic [CW:0]   ROW_PIXELS  = (CW + 1)'(N_COLS);
    localparam logic [31:0]   ROW_BYTES   = 32'(N_COLS * 3);
    localparam logic [31:0]   FRAME_BYTES = 32'(N_BANKS * N_ROWS * N_COLS * 3);

    typedef enum logic [2:0] {
        IDLE, REQ, DATA, STORE, ROW_WAIT, ROW_SWAP, FRAME_WAIT, FRAME_SWAP
    } state_t;

    state_t                state_q;
    logic [RW-1:0]         row_q;
    logic [FW-1:0]         frame_q;
    logic [15:0]           asm_q;
    logic [1:0]            bcnt_q;
    logic [CW:0]           pix_q;
    logic [23:0]           sr_addr_q, sr_addr_d;
    logic                  sr_go_q, wren_q, store_q, rswap_q, fswap_q;
    logic [BITDEPTH-1:0]   data_q;
    logic [CW-1:0]         col_q;

    // Address arithmetic wraps at the 24-bit flash address space.
    always_comb begin
        sr_addr_d = BASE_ADDR + 24'(32'(frame_q) * FRAME_BYTES) + 24'(32'(row_q) * ROW_BYTES);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            frame_q   <= '0;
            asm_q     <= '0;
            bcnt_q    <= '0;
            pix_q     <= '0;
            sr_addr_q <= BASE_ADDR;
            sr_go_q   <= 1'b0;
            wren_q    <= 1'b0;
            store_q   <= 1'b0;
            rswap_q   <= 1'b0;
            fswap_q   <= 1'b0;
            data_q    <= '0;
            col_q     <= '0;
        end else begin
            sr_go_q <= 1'b0;
            wren_q  <= 1'b0;
            store_q <= 1'b0;
            rswap_q <= 1'b0;
            fswap_q <= 1'b0;
            case (state_q)
                IDLE: if (enable && sr_rdy) begin
                    state_q   <= REQ;
                    sr_go_q   <= 1'b1;
                    sr_addr_q <= sr_addr_d;
                    asm_q     <= '0;
                    bcnt_q    <= '0;
                    pix_q     <= '0;
                end
                REQ: state_q <= DATA;
                // Row is complete once the last pixel write has already been issued.
                DATA: if (pix_q == ROW_PIXELS) begin
                    state_q <= STORE;
                    store_q <= 1'b1;
                end else if (sr_valid) begin
                    asm_q  <= {asm_q[7:0], sr_data};
                    bcnt_q <= bcnt_q == 2'd2 ? 2'd0 : bcnt_q + 2'd1;
                    if (bcnt_q == 2'd2) begin
                        wren_q <= 1'b1;
                        data_q <= BITDEPTH'({asm_q, sr_data});
                        col_q  <= pix_q[CW-1:0];
                        pix_q  <= pix_q + 1'b1;
                    end
                end
                STORE: state_q <= ROW_WAIT;
                ROW_WAIT: if (fbw_row_rdy) begin
                    state_q <= ROW_SWAP;
                    rswap_q <= 1'b1;
                end
                ROW_SWAP: begin
                    row_q   <= row_q == LAST_ROW ? '0 : row_q + 1'b1;
                    state_q <= row_q == LAST_ROW ? FRAME_WAIT : IDLE;
                end
                FRAME_WAIT: if (frame_rdy) begin
                    state_q <= FRAME_SWAP;
                    fswap_q <= 1'b1;
                end
                FRAME_SWAP: begin
                    frame_q <= frame_q == LAST_FRAME ? '0 : frame_q + 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sr_addr       = sr_addr_q;
    assign sr_len        = 16'(N_COLS * 3 - 1);
    assign sr_go         = sr_go_q;
    assign fbw_row_addr  = row_q;
    assign fbw_col_addr  = col_q;
    assign fbw_data      = data_q;
    assign fbw_wren      = wren_q;
    assign fbw_row_store = store_q;
    assign fbw_row_swap  = rswap_q;
    assign frame_swap    = fswap_q;
endmodule

// File: tb/tb_fb_flash_loader.sv
// tb_fb_flash_loader: scoreboard bench for fb_flash_loader; stimulus queues expected events,
// a negedge monitor pops and compares whenever the DUT raises a strobe.
module tb_fb_flash_loader;
    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, sr_rdy = 1'b0, sr_valid = 1'b0;
    logic        fbw_row_rdy = 1'b0, frame_rdy = 1'b0;
    logic [7:0]  sr_data = 8'h00;
    logic [23:0] sr_addr;
    logic [15:0] sr_len;
    logic        sr_go, fbw_wren, fbw_row_store, fbw_row_swap, frame_swap;
    logic [5:0]  fbw_row_addr, fbw_col_addr;
    logic [23:0] fbw_data;

    fb_flash_loader dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .sr_addr(sr_addr), .sr_len(sr_len), .sr_go(sr_go), .sr_rdy(sr_rdy),
        .sr_data(sr_data), .sr_valid(sr_valid),
        .fbw_row_addr(fbw_row_addr), .fbw_col_addr(fbw_col_addr), .fbw_data(fbw_data),
        .fbw_wren(fbw_wren), .fbw_row_store(fbw_row_store), .fbw_row_rdy(fbw_row_rdy),
        .fbw_row_swap(fbw_row_swap), .frame_rdy(frame_rdy), .frame_swap(frame_swap)
    );

    always #5 clk = ~clk;

    localparam int K_GO = 0, K_WR = 1, K_ST = 2, K_RS = 3, K_FS = 4;
    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
    } ev_t;

    ev_t sb[$];
    int  n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got event/timeout expected none", name);
    endtask

    task automatic push(input int k, input logic [31:0] a, input logic [31:0] b);
        sb.push_back('{k, a, b});
    endtask

    task automatic pop_chk(input string name, input int k, input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        if (sb.size() == 0) begin
            fail_now({"unexpected_", name});
            return;
        end
        e = sb.pop_front();
        chk({name, "_kind"}, 32'(k), 32'(e.kind));
        chk({name, "_a"}, a, e.a);
        chk({name, "_b"}, b, e.b);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("strobes_in_reset", {27'd0, sr_go, fbw_wren, fbw_row_store, fbw_row_swap, frame_swap}, 32'd0);
        end else begin
            if (sr_go)         pop_chk("go", K_GO, 32'(sr_addr), 32'(sr_len));
            if (fbw_wren)      pop_chk("wr", K_WR, 32'(fbw_col_addr), 32'(fbw_data));
            if (fbw_row_store) pop_chk("store", K_ST, 32'(fbw_row_addr), 32'd0);
            if (fbw_row_swap)  pop_chk("row_swap", K_RS, 32'(fbw_row_addr), 32'd0);
            if (frame_swap)    pop_chk("frame_swap", K_FS, 32'd0, 32'd0);
        end
    end

    function automatic logic [7:0] byte_of(input int gr, input int k);
        return 8'(k + gr);
    endfunction

    function automatic logic [23:0] pix_of(input int gr, input int p);
        if (gr == 0 && p == 0)  return 24'h000102;
        if (gr == 0 && p == 63) return 24'hBDBEBF;
        return {byte_of(gr, 3 * p), byte_of(gr, 3 * p + 1), byte_of(gr, 3 * p + 2)};
    endfunction

    task automatic check_reset();
        chk("rst_sr_addr", 32'(sr_addr), 32'h100000);
        chk("rst_sr_len", 32'(sr_len), 32'd191);
        chk("rst_row_addr", 32'(fbw_row_addr), 32'd0);
        chk("rst_col_addr", 32'(fbw_col_addr), 32'd0);
        chk("rst_data", 32'(fbw_data), 32'd0);
    endtask

    task automatic wait_go();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sr_go) return;
        end
        fail_now("go_timeout");
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0) return;
            @(negedge clk);
        end
        fail_now({name, "_drain_timeout"});
        sb.delete();
    endtask

    task automatic do_row(input int f, input int r, input int gr, input int row_delay, input bit cut);
        int nbytes = cut ? 50 : 192;
        int npix   = cut ? 16 : 64;
        push(K_GO, 32'h100000 + 32'(f) * 32'h3000 + 32'(r) * 32'hC0, 32'd191);
        enable = 1'b1;
        sr_rdy = 1'b1;
        wait_go();
        enable   = 1'b0;
        sr_rdy   = 1'b0;
        sr_valid = 1'b1;
        sr_data  = 8'hEE;
        @(negedge clk);
        for (int p = 0; p < npix; p++) push(K_WR, 32'(p), 32'(pix_of(gr, p)));
        if (!cut) begin
            push(K_ST, 32'(r), 32'd0);
            push(K_RS, 32'(r), 32'd0);
        end
        for (int k = 0; k < nbytes; k++) begin
            sr_data  = byte_of(gr, k);
            sr_valid = 1'b1;
            @(negedge clk);
        end
        if (cut) begin
            rst_n = 1'b0;
            for (int k = 0; k < 10; k++) begin
                sr_data = 8'(k);
                @(negedge clk);
            end
            sr_valid = 1'b0;
            chk("cut_pending_events", 32'(sb.size()), 32'd0);
            check_reset();
            rst_n = 1'b1;
            @(negedge clk);
            return;
        end
        sr_valid = 1'b0;
        if (row_delay > 0) begin
            fbw_row_rdy = 1'b0;
            repeat (row_delay) @(negedge clk);
            chk("row_wait_no_swap", 32'(fbw_row_swap), 32'd0);
            fbw_row_rdy = 1'b1;
            @(negedge clk);
            chk("row_swap_latency", 32'(fbw_row_swap), 32'd1);
        end
        drain("row");
        @(negedge clk);
        chk("next_row_addr", 32'(fbw_row_addr), 32'((r + 1) % 64));
        if (r == 63) begin
            repeat (10) @(negedge clk);
            chk("frame_wait_no_go", 32'(sr_go), 32'd0);
            push(K_FS, 32'd0, 32'd0);
            frame_rdy = 1'b1;
            @(negedge clk);
            chk("frame_swap_latency", 32'(frame_swap), 32'd1);
            frame_rdy = 1'b0;
            drain("frame");
        end
    endtask

    initial begin
        int gr = 0;
        repeat (3) @(negedge clk);
        check_reset();
        rst_n = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 4; f++) begin
            for (int r = 0; r < 64; r++) begin
                do_row(f, r, gr, gr == 0 ? 10 : 0, 1'b0);
                gr++;
            end
        end
        do_row(0, 0, gr, 0, 1'b0);
        gr++;
        do_row(0, 1, gr, 0, 1'b1);
        gr++;
        do_row(0, 0, gr, 0, 1'b0);
        repeat (5) @(negedge clk);
        chk("final_queue_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
